// File: rtl/z480_pkg.sv
// z480_pkg: shared definitions for the Z480 execute-cluster branch unit.
//   - branch op encodings carried on in_op
//   - bit positions inside the 32-bit writeback flag word
//   - branch unit control state enum
//   - small decode helper shared by the datapath
package z480_pkg;

  localparam logic [3:0] Z480_BR_BEQ  = 4'd0;
  localparam logic [3:0] Z480_BR_BNE  = 4'd1;
  localparam logic [3:0] Z480_BR_BLT  = 4'd2;
  localparam logic [3:0] Z480_BR_BGE  = 4'd3;
  localparam logic [3:0] Z480_BR_BLTU = 4'd4;
  localparam logic [3:0] Z480_BR_BGEU = 4'd5;
  localparam logic [3:0] Z480_BR_JAL  = 4'd6;
  localparam logic [3:0] Z480_BR_JALR = 4'd7;

  localparam int Z480_WBF_MISPRED = 0;
  localparam int Z480_WBF_TAKEN   = 1;
  localparam int Z480_WBF_ILLEGAL = 2;
  localparam int Z480_WBF_USED_W  = 3;

  typedef enum logic {
    Z480_ST_RUN   = 1'b0,
    Z480_ST_DRAIN = 1'b1
  } z480_br_state_e;

  function automatic logic z480_is_jump(input logic [3:0] op);
    return (op == Z480_BR_JAL) || (op == Z480_BR_JALR);
  endfunction

endpackage

// File: rtl/z480_wb_fifo.sv
// z480_wb_fifo: generic synchronous FIFO used as the writeback queue of the
// execute units.
//   clk, rst        clock, asynchronous active-high reset
//   clear           synchronous empty (pipeline flush); wins over push/pop
//   push, push_data write one entry; ignored when full unless popping too
//   pop             drop the head entry; ignored when empty
//   pop_data        head entry (only meaningful while !empty)
//   empty, full     occupancy flags
// DEPTH must be a power of two >= 1. A push and pop in the same cycle while
// full is legal: the head leaves and the new entry takes the freed slot.
module z480_wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Explicit wrap keeps DEPTH == 1 (single slot, pointer pinned at 0) correct.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (p == PTR_W'(DEPTH - 1)) n = '0;
    else                        n = p + 1'b1;
    return n;
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; consumers only look at it while !empty.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/z480_branch_unit.sv
// z480_branch_unit: resolves conditional branches and JAL/JALR, checks the
// outcome against the front-end prediction, raises a one-cycle redirect on
// mispredict and queues results for the shared completion bus.
//   clk, rst                 clock, asynchronous active-high reset
//   flush                    ROB flush: empties queue, cancels redirect, back to RUN
//   in_*                     uop offer (valid/ready handshake) with operands and prediction
//   wb_*                     writeback entry (valid/ready), flags: mispredict/taken/illegal
//   redirect_valid/_pc       registered redirect pulse and correct next PC
//   mispredict_count         saturating count of mispredicts accepted in RUN
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | normal operation, accepted uops are resolved and queued
// DRAIN | redirect issued, wrong-path uops are accepted and dropped until flush
module z480_branch_unit
  import z480_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int ROB_W    = 6,
  parameter int PRD_W    = 7,
  parameter int WB_DEPTH = 2,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ROB_W-1:0] in_rob_idx,
  input  logic             in_prd_valid,
  input  logic [PRD_W-1:0] in_prd,
  input  logic [3:0]       in_op,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic             in_pred_taken,
  input  logic [XLEN-1:0]  in_pred_target,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [ROB_W-1:0] wb_rob_idx,
  output logic             wb_prd_valid,
  output logic [PRD_W-1:0] wb_prd,
  output logic [XLEN-1:0]  wb_value,
  output logic [31:0]      wb_flags,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int ENT_W = ROB_W + 1 + PRD_W + XLEN + Z480_WBF_USED_W;

  // Resolution datapath
  logic                       src_eq, src_lt_s, src_lt_u;
  logic                       res_taken, res_illegal, res_mispred, res_is_jump;
  logic [XLEN-1:0]            jalr_sum, res_target, res_fallthrough;

  // Queue entry fields
  logic                       ent_prd_valid;
  logic [PRD_W-1:0]           ent_prd;
  logic [XLEN-1:0]            ent_value;
  logic [Z480_WBF_USED_W-1:0] ent_flags;
  logic [ENT_W-1:0]           push_entry, pop_entry;

  logic [ROB_W-1:0]           pop_rob_idx;
  logic                       pop_prd_valid;
  logic [PRD_W-1:0]           pop_prd;
  logic [XLEN-1:0]            pop_value;
  logic [Z480_WBF_USED_W-1:0] pop_flags;

  logic                       fifo_empty, fifo_full, fifo_has_entry;
  logic                       accept, push, pop;

  z480_br_state_e             state_q, state_d;
  logic                       redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]            redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0]           mis_cnt_q, mis_cnt_d;

  always_comb begin
    src_eq          = (in_src1 == in_src2);
    src_lt_s        = ($signed(in_src1) < $signed(in_src2));
    src_lt_u        = (in_src1 < in_src2);
    res_taken       = 1'b0;
    res_illegal     = 1'b0;
    res_is_jump     = z480_is_jump(in_op);
    case (in_op)
      Z480_BR_BEQ:  res_taken = src_eq;
      Z480_BR_BNE:  res_taken = !src_eq;
      Z480_BR_BLT:  res_taken = src_lt_s;
      Z480_BR_BGE:  res_taken = !src_lt_s;
      Z480_BR_BLTU: res_taken = src_lt_u;
      Z480_BR_BGEU: res_taken = !src_lt_u;
      Z480_BR_JAL:  res_taken = 1'b1;
      Z480_BR_JALR: res_taken = 1'b1;
      default:      res_illegal = 1'b1;
    endcase

    jalr_sum        = in_src1 + in_imm;
    res_fallthrough = in_pc + XLEN'(4);
    if (in_op == Z480_BR_JALR) res_target = {jalr_sum[XLEN-1:1], 1'b0};
    else                       res_target = in_pc + in_imm;

    // A correct direction with a wrong target still counts when taken.
    res_mispred = (res_taken != in_pred_taken) ||
                  (res_taken && (res_target != in_pred_target));

    ent_prd_valid = res_is_jump ? in_prd_valid    : 1'b0;
    ent_prd       = res_is_jump ? in_prd          : '0;
    ent_value     = res_is_jump ? res_fallthrough : '0;
    ent_flags                   = '0;
    ent_flags[Z480_WBF_MISPRED] = res_mispred;
    ent_flags[Z480_WBF_TAKEN]   = res_taken;
    ent_flags[Z480_WBF_ILLEGAL] = res_illegal;
  end

  assign push_entry = {in_rob_idx, ent_prd_valid, ent_prd, ent_value, ent_flags};
  assign {pop_rob_idx, pop_prd_valid, pop_prd, pop_value, pop_flags} = pop_entry;

  z480_wb_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (WB_DEPTH)
  ) u_wb_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (pop_entry),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Entries are hidden during a flush cycle so the completion bus never takes
  // one that is being discarded. Fields are zeroed whenever nothing is queued.
  assign fifo_has_entry = !fifo_empty;
  assign wb_valid       = fifo_has_entry && !flush;
  assign wb_rob_idx     = fifo_has_entry ? pop_rob_idx   : '0;
  assign wb_prd_valid   = fifo_has_entry ? pop_prd_valid : 1'b0;
  assign wb_prd         = fifo_has_entry ? pop_prd       : '0;
  assign wb_value       = fifo_has_entry ? pop_value     : '0;
  assign wb_flags       = fifo_has_entry ? {{(32-Z480_WBF_USED_W){1'b0}}, pop_flags} : '0;

  assign redirect_valid   = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;
  assign mispredict_count = mis_cnt_q;

  always_comb begin
    in_ready = 1'b0;
    if (!flush) begin
      if (state_q == Z480_ST_DRAIN) in_ready = 1'b1;
      else                          in_ready = !fifo_full || wb_ready;
    end
    accept = in_valid && in_ready;
    push   = accept && (state_q == Z480_ST_RUN);
    pop    = wb_valid && wb_ready;

    state_d          = state_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    mis_cnt_d        = mis_cnt_q;
    if (flush) begin
      state_d = Z480_ST_RUN;
    end else if (push && res_mispred) begin
      state_d          = Z480_ST_DRAIN;
      redirect_valid_d = 1'b1;
      redirect_pc_d    = res_taken ? res_target : res_fallthrough;
      if (!(&mis_cnt_q)) mis_cnt_d = mis_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= Z480_ST_RUN;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      mis_cnt_q        <= '0;
    end else begin
      state_q          <= state_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      mis_cnt_q        <= mis_cnt_d;
    end
  end

endmodule

// File: tb/tb_z480_branch_unit.sv
module tb_z480_branch_unit;

  localparam int XLEN     = 64;
  localparam int ROB_W    = 6;
  localparam int PRD_W    = 7;
  localparam int WB_DEPTH = 2;
  localparam int CNT_W    = 3;
  localparam int CMAX     = (1 << CNT_W) - 1;
  localparam logic [63:0] M1 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic             clk, rst, flush;
  logic             in_valid, in_ready, in_prd_valid, in_pred_taken;
  logic [ROB_W-1:0] in_rob_idx;
  logic [PRD_W-1:0] in_prd;
  logic [3:0]       in_op;
  logic [XLEN-1:0]  in_pc, in_imm, in_src1, in_src2, in_pred_target;
  logic             wb_valid, wb_ready, wb_prd_valid, redirect_valid;
  logic [ROB_W-1:0] wb_rob_idx;
  logic [PRD_W-1:0] wb_prd;
  logic [XLEN-1:0]  wb_value, redirect_pc;
  logic [31:0]      wb_flags;
  logic [CNT_W-1:0] mispredict_count;

  z480_branch_unit #(
    .XLEN(XLEN), .ROB_W(ROB_W), .PRD_W(PRD_W), .WB_DEPTH(WB_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_rob_idx(in_rob_idx),
    .in_prd_valid(in_prd_valid), .in_prd(in_prd), .in_op(in_op),
    .in_pc(in_pc), .in_imm(in_imm), .in_src1(in_src1), .in_src2(in_src2),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rob_idx(wb_rob_idx),
    .wb_prd_valid(wb_prd_valid), .wb_prd(wb_prd), .wb_value(wb_value),
    .wb_flags(wb_flags), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mispredict_count(mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] pc, imm, src1, src2;
    logic        pt;
    logic [63:0] ptgt;
    logic        prdv;
    logic [6:0]  prd;
    logic [31:0] flags;
    logic        eprdv;
    logic [6:0]  eprd;
    logic [63:0] value;
    logic [63:0] rpc;
  } vec_t;

  typedef struct {
    logic [5:0]  rob;
    logic        prdv;
    logic [6:0]  prd;
    logic [63:0] value;
    logic [31:0] flags;
  } exp_t;

  vec_t  vecs[12];
  exp_t  sb[$];
  exp_t  cur_exp;
  logic  cur_mis;
  logic [63:0] cur_rpc;
  logic  m_drain, m_redir;
  logic [63:0] m_rpc;
  int    m_count;
  int    n_chk, n_err;

  function automatic vec_t mk(input logic [3:0] op, input logic [63:0] pc, imm, s1, s2,
                              input logic pt, input logic [63:0] ptgt, input logic prdv,
                              input logic [6:0] prd, input logic [31:0] flags,
                              input logic eprdv, input logic [6:0] eprd,
                              input logic [63:0] value, rpc);
    vec_t v;
    v.op = op; v.pc = pc; v.imm = imm; v.src1 = s1; v.src2 = s2; v.pt = pt;
    v.ptgt = ptgt; v.prdv = prdv; v.prd = prd; v.flags = flags; v.eprdv = eprdv;
    v.eprd = eprd; v.value = value; v.rpc = rpc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v, input logic [5:0] rob);
    in_valid = 1'b1; in_op = v.op; in_pc = v.pc; in_imm = v.imm; in_src1 = v.src1;
    in_src2 = v.src2; in_pred_taken = v.pt; in_pred_target = v.ptgt;
    in_prd_valid = v.prdv; in_prd = v.prd; in_rob_idx = rob;
    cur_exp = '{rob, v.eprdv, v.eprd, v.value, v.flags};
    cur_mis = v.flags[0];
    cur_rpc = v.rpc;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // One clock cycle: check outputs against the model, update the model, advance.
  task automatic cyc();
    logic exp_rdy, exp_wbv, acc;
    exp_t e;
    #1;
    exp_wbv = (sb.size() > 0) && !flush;
    exp_rdy = flush ? 1'b0 : (m_drain ? 1'b1 : ((sb.size() < WB_DEPTH) || wb_ready));
    chk("in_ready", in_ready, exp_rdy);
    chk("wb_valid", wb_valid, exp_wbv);
    chk("redirect_valid", redirect_valid, m_redir);
    if (m_redir) chk("redirect_pc", redirect_pc, m_rpc);
    chk("mispredict_count", mispredict_count, m_count);
    if (exp_wbv) begin
      e = sb[0];
      chk("wb_rob_idx", wb_rob_idx, e.rob);
      chk("wb_prd_valid", wb_prd_valid, e.prdv);
      chk("wb_prd", wb_prd, e.prd);
      chk("wb_value", wb_value, e.value);
      chk("wb_flags", wb_flags, e.flags);
      if (wb_ready) void'(sb.pop_front());
    end
    acc = in_valid && exp_rdy;
    m_redir = 1'b0;
    if (flush) begin
      sb.delete();
      m_drain = 1'b0;
    end else if (acc && !m_drain) begin
      sb.push_back(cur_exp);
      if (cur_mis) begin
        m_drain = 1'b1;
        m_redir = 1'b1;
        m_rpc   = cur_rpc;
        if (m_count != CMAX) m_count++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0; n_err = 0; m_count = 0; m_drain = 0; m_redir = 0; m_rpc = '0;
    rst = 1'b1; flush = 1'b0; wb_ready = 1'b0;
    in_valid = 0; in_rob_idx = 0; in_prd_valid = 0; in_prd = 0; in_op = 0;
    in_pc = 0; in_imm = 0; in_src1 = 0; in_src2 = 0; in_pred_taken = 0; in_pred_target = 0;
    cur_exp = '{6'd0, 1'b0, 7'd0, 64'd0, 32'd0}; cur_mis = 0; cur_rpc = 0;

    //              op     pc                      imm                     src1     src2   pt ptgt      prdv prd flags eprdv eprd value     rpc
    vecs[0]  = mk(4'd0,  64'h1000,               64'h40,                 64'd5,   64'd5, 1, 64'h1040, 1, 7'd4, 32'h2, 0, 7'd0, 64'h0,    64'h0);
    vecs[1]  = mk(4'd2,  64'h2000,               64'h10,                 M1,      64'd1, 0, 64'h0,    0, 7'd0, 32'h3, 0, 7'd0, 64'h0,    64'h2010);
    vecs[2]  = mk(4'd7,  64'h500,                64'h4,                  64'h3001,64'd0, 1, 64'h3004, 1, 7'd9, 32'h2, 1, 7'd9, 64'h504,  64'h0);
    vecs[3]  = mk(4'd4,  64'h100,                64'h20,                 M1,      64'd1, 0, 64'h0,    0, 7'd0, 32'h0, 0, 7'd0, 64'h0,    64'h0);
    vecs[4]  = mk(4'd3,  64'h300,                64'h100,                M1,      64'd1, 1, 64'h400,  0, 7'd0, 32'h1, 0, 7'd0, 64'h0,    64'h304);
    vecs[5]  = mk(4'd5,  64'h1000,               64'h234,                M1,      64'd1, 1, 64'h1234, 0, 7'd0, 32'h2, 0, 7'd0, 64'h0,    64'h0);
    vecs[6]  = mk(4'd1,  64'h40,                 64'h8,                  64'd3,   64'd3, 0, 64'h0,    0, 7'd0, 32'h0, 0, 7'd0, 64'h0,    64'h0);
    vecs[7]  = mk(4'd6,  64'h8000,               64'hFFFF_FFFF_FFFF_FFF0,64'd0,   64'd0, 1, 64'h7000, 1, 7'd5, 32'h3, 1, 7'd5, 64'h8004, 64'h7FF0);
    vecs[8]  = mk(4'd9,  64'h700,                64'h0,                  64'd0,   64'd0, 0, 64'h0,    1, 7'd3, 32'h4, 0, 7'd0, 64'h0,    64'h0);
    vecs[9]  = mk(4'd15, 64'h600,                64'h0,                  64'd0,   64'd0, 1, 64'h800,  0, 7'd0, 32'h5, 0, 7'd0, 64'h0,    64'h604);
    vecs[10] = mk(4'd6,  64'hFFFF_FFFF_FFFF_FFFC,64'h8,                  64'd0,   64'd0, 1, 64'h4,    0, 7'd2, 32'h2, 0, 7'd2, 64'h0,    64'h0);
    vecs[11] = mk(4'd0,  64'h900,                64'h10,                 64'd1,   64'd2, 1, 64'h910,  0, 7'd0, 32'h1, 0, 7'd0, 64'h0,    64'h904);

    // Reset state
    #12;
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_count", mispredict_count, 0);
    chk("rst_wb_flags", wb_flags, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Table: each vector alone, popped next cycle, flushed if it mispredicted
    wb_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i], 6'(i + 1)); cyc();
      idle(); cyc();
      if (vecs[i].flags[0]) begin flush = 1'b1; cyc(); flush = 1'b0; end
    end

    // Mispredict, then wrong-path uops discarded until flush
    drive(vecs[1], 6'd20); cyc();
    drive(vecs[0], 6'd21); cyc();
    drive(vecs[2], 6'd22); cyc();
    flush = 1'b1; cyc(); flush = 1'b0;
    idle(); cyc(); cyc();

    // Backpressure: two accepted, third held off, then pop and push together
    wb_ready = 1'b0;
    drive(vecs[0], 6'd30); cyc();
    drive(vecs[2], 6'd31); cyc();
    drive(vecs[6], 6'd32); cyc(); cyc();
    wb_ready = 1'b1; cyc();
    idle(); cyc(); cyc(); cyc();

    // Flush while full and in DRAIN
    wb_ready = 1'b0;
    drive(vecs[0], 6'd40); cyc();
    drive(vecs[1], 6'd41); cyc();
    drive(vecs[2], 6'd42); cyc();
    flush = 1'b1; cyc(); flush = 1'b0;
    cyc();
    idle(); wb_ready = 1'b1; cyc(); cyc();

    // Flush coinciding with a mispredicting offer in RUN: nothing accepted
    drive(vecs[11], 6'd50); flush = 1'b1; cyc(); flush = 1'b0;
    idle(); cyc(); cyc();

    // Asynchronous reset mid-operation
    wb_ready = 1'b0;
    drive(vecs[1], 6'd55); cyc();
    idle();
    #1;
    chk("pre_rst_redirect", redirect_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_wb_valid", wb_valid, 0);
    chk("arst_redirect_valid", redirect_valid, 0);
    chk("arst_count", mispredict_count, 0);
    chk("arst_in_ready", in_ready, 1);
    sb.delete(); m_drain = 0; m_redir = 0; m_count = 0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    wb_ready = 1'b1;
    drive(vecs[2], 6'd56); cyc();
    idle(); cyc(); cyc();

    // 2^CNT_W + 1 mispredicts: counter saturates
    for (int k = 0; k < (1 << CNT_W) + 1; k++) begin
      drive(vecs[11], 6'(k)); cyc();
      idle(); cyc();
      flush = 1'b1; cyc(); flush = 1'b0;
    end
    chk("sat_count", mispredict_count, 64'd7);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
